// File: rtl/regbank_writeback_queue.sv
// In-order writeback queue: buffers load/ALU results, retires one register-bank write per cycle and
// flags decode hazards on queued non-head writes. Define WBQ_STATS_EN for occupancy/full_stalls outputs.
module regbank_writeback_queue #(
  parameter int DEPTH     = 4,
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [WORD_SIZE-1:0] alu_data,
  output logic                 we,
  output logic [ADDR_W-1:0]    regRD_addr,
  output logic [WORD_SIZE-1:0] regRD_data,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic                 hazard_stall
`ifdef WBQ_STATS_EN
  ,
  output logic [ADDR_W:0]      occupancy,
  output logic [15:0]          full_stalls
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int F_W   = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [WORD_SIZE-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, alu_slot, hz_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic [F_W-1:0]   free_slots;
  logic             pop, ld_uses_slot, ld_push, alu_push;

  // The head always retires, so its slot is already free for this edge's pushes.
  assign pop          = (count_q != '0);
  assign free_slots   = F_W'(DEPTH) - F_W'(count_q) + F_W'(pop);
  assign ld_uses_slot = ld_valid && (ld_addr != '0);
  assign ld_ready     = (free_slots != '0);
  assign alu_ready    = (free_slots >= F_W'(2)) || ((free_slots == F_W'(1)) && !ld_uses_slot);
  assign ld_push      = ld_uses_slot && ld_ready;
  assign alu_push     = alu_valid && alu_ready && (alu_addr != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(ld_push) + PTR_W'(alu_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(ld_push) + CNT_W'(alu_push) - CNT_W'(pop);
    alu_slot = ld_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count covers it.
  always_ff @(posedge clk) begin
    if (ld_push)  mem_q[wr_ptr_q] <= {ld_addr, ld_data};
    if (alu_push) mem_q[alu_slot] <= {alu_addr, alu_data};
  end

  assign we         = pop;
  assign regRD_addr = pop ? mem_q[rd_ptr_q].addr : '0;
  assign regRD_data = pop ? mem_q[rd_ptr_q].data : '0;

  // The bank forwards the head itself; only younger entries can stall decode.
  always_comb begin
    hazard_stall = 1'b0;
    hz_idx       = '0;
    for (int i = 1; i < DEPTH; i++) begin
      hz_idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (((rs1_addr != '0) && (mem_q[hz_idx].addr == rs1_addr)) ||
            ((rs2_addr != '0) && (mem_q[hz_idx].addr == rs2_addr)))
          hazard_stall = 1'b1;
      end
    end
  end

`ifdef WBQ_STATS_EN
  logic [15:0] full_stalls_q, full_stalls_d;
  logic        blocked;

  assign blocked = (ld_valid && !ld_ready) || (alu_valid && !alu_ready);

  always_comb begin
    full_stalls_d = full_stalls_q;
    if (blocked && (full_stalls_q != 16'hFFFF)) full_stalls_d = full_stalls_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) full_stalls_q <= '0;
    else      full_stalls_q <= full_stalls_d;
  end

  assign occupancy   = (ADDR_W + 1)'(count_q);
  assign full_stalls = full_stalls_q;
`endif

endmodule

// File: tb/tb_regbank_writeback_queue.sv
// Directed bench with a queue scoreboard; expected writes are queued as results are accepted.
`timescale 1ns/100ps
module tb_regbank_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0, alu_valid = 1'b0;
  logic        ld_ready, alu_ready, we, hazard_stall;
  logic [3:0]  ld_addr = '0, alu_addr = '0, rs1_addr = '0, rs2_addr = '0, regRD_addr;
  logic [15:0] ld_data = '0, alu_data = '0, regRD_data;
`ifdef WBQ_STATS_EN
  logic [4:0]  occupancy;
  logic [15:0] full_stalls;
  int          exp_stalls = 0;
`endif

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  logic acc;
  int  alu_seq;

  always #10 clk = ~clk;

  regbank_writeback_queue #(.DEPTH(DEPTH), .WORD_SIZE(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .we(we), .regRD_addr(regRD_addr), .regRD_data(regRD_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard_stall(hazard_stall)
`ifdef WBQ_STATS_EN
    , .occupancy(occupancy), .full_stalls(full_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_hazard();
    logic h = 1'b0;
    for (int i = 1; i < sb.size(); i++)
      if ((rs1_addr != 0 && sb[i].addr == rs1_addr) || (rs2_addr != 0 && sb[i].addr == rs2_addr))
        h = 1'b1;
    return h;
  endfunction

  // Called at a falling edge: drive, check, advance the scoreboard across the next rising edge.
  task automatic cycle(input logic lv, input logic [3:0] la, input logic [15:0] ldd,
                       input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       output logic alu_acc);
    int n, f;
    logic e_lr, e_ar, lslot;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
    n = sb.size();
    f = DEPTH - n + ((n != 0) ? 1 : 0);
    lslot = lv && (la != 0);
    e_lr = (f >= 1);
    e_ar = (f >= 2) || ((f == 1) && !lslot);
    check("ld_ready", 32'(ld_ready), 32'(e_lr));
    check("alu_ready", 32'(alu_ready), 32'(e_ar));
    check("we", 32'(we), 32'(n != 0));
    check("wr_addr", 32'(regRD_addr), (n != 0) ? 32'(sb[0].addr) : 32'd0);
    check("wr_data", 32'(regRD_data), (n != 0) ? 32'(sb[0].data) : 32'd0);
    check("hazard", 32'(hazard_stall), 32'(exp_hazard()));
`ifdef WBQ_STATS_EN
    check("occupancy", 32'(occupancy), 32'(n));
    check("full_stalls", 32'(full_stalls), 32'(exp_stalls));
    if (((lv && !e_lr) || (av && !e_ar)) && exp_stalls != 16'hFFFF) exp_stalls++;
`endif
    if (n != 0) void'(sb.pop_front());
    if (lslot && e_lr) sb.push_back('{addr: la, data: ldd});
    if (av && e_ar && aa != 0) sb.push_back('{addr: aa, data: ad});
    alu_acc = av && e_ar;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic dummy;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, dummy);
  endtask

  task automatic probe(input logic [3:0] a1, input logic [3:0] a2, input string tag);
    rs1_addr = a1; rs2_addr = a2;
    #1;
    check(tag, 32'(hazard_stall), 32'(exp_hazard()));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 16'h5555;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'h6666;
    rs1_addr = '0; rs2_addr = '0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    ld_valid = 1'b0; alu_valid = 1'b0;
    sb.delete();
`ifdef WBQ_STATS_EN
    exp_stalls = 0;
`endif
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(regRD_addr), 32'd0);
    check("rst_data", 32'(regRD_data), 32'd0);
    check("rst_hazard", 32'(hazard_stall), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
`ifdef WBQ_STATS_EN
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_full_stalls", 32'(full_stalls), 32'd0);
`endif
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);
    idle(1);

    // Single ALU write, then two same-edge writes retiring load first.
    cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1234, acc);
    idle(2);
    cycle(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, acc);
    idle(3);

    // Fill with both producers; ALU held until accepted.
    alu_seq = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 4'(k + 1), 16'h1000 + 16'(k), 1'b1, 4'(8 + alu_seq), 16'h2000 + 16'(alu_seq), acc);
      if (acc) alu_seq++;
    end
    // An r0 load at full must leave the last slot to the ALU.
    cycle(1'b1, 4'd0, 16'hDEAD, 1'b1, 4'(8 + alu_seq), 16'h2000 + 16'(alu_seq), acc);
    idle(5);

    // Hazard against non-head entries only.
    cycle(1'b1, 4'd7, 16'h0707, 1'b1, 4'd9, 16'h0909, acc);
    probe(4'd9, 4'd0, "hz_rs1_nonhead");
    probe(4'd7, 4'd0, "hz_rs1_head");
    probe(4'd0, 4'd9, "hz_rs2_nonhead");
    probe(4'd0, 4'd0, "hz_r0");
    idle(3);

    // Writes to r0 are accepted and dropped.
    cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hFFFF, acc);
    check("r0_accepted", 32'(acc), 32'd1);
    idle(2);

    // Reset with writes pending drops them.
    cycle(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, acc);
    cycle(1'b1, 4'd3, 16'h0303, 1'b1, 4'd4, 16'h0404, acc);
    do_reset(1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
